// File: rtl/led_pattern_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
// Holds the mode encodings, the blink-code sequencer states and the phase width helper.
// Pure definitions only; this file holds no logic.
package led_pattern_pkg;

  localparam logic [2:0] MODE_OFF  = 3'd0;
  localparam logic [2:0] MODE_ON   = 3'd1;
  localparam logic [2:0] MODE_SLOW = 3'd2;
  localparam logic [2:0] MODE_FAST = 3'd3;
  localparam logic [2:0] MODE_CODE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } code_state_e;

  // Width of a phase counter that must reach (largest tick count - 1).
  function automatic int phase_width(input int a, input int b, input int c,
                                     input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Mode/code request bus into the LED generator and the LED/WRAP outputs back.
// LED and WRAP are registered inside the generator, one cycle behind MODE/CODE.
// No backpressure: MODE/CODE are level inputs sampled every cycle.
interface led_pattern_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CODE_W   = 4
);
  logic [3*CHANNELS-1:0]      MODE;
  logic [CODE_W*CHANNELS-1:0] CODE;
  logic [CHANNELS-1:0]        LED;
  logic [CHANNELS-1:0]        WRAP;

  // Status logic side: requests patterns, observes LEDs.
  modport master (output MODE, output CODE, input LED, input WRAP);
  // Generator side.
  modport slave  (input MODE, input CODE, output LED, output WRAP);
endinterface

// File: rtl/led_pattern_chan.sv
// One LED channel sequencer: off, on, slow/fast blink or repeating N-flash code.
// Latency: a mode/code change shows on led one cycle later; pattern steps on tick.
// No backpressure: tick and mode/code are consumed every cycle.
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int SLOW_TICKS     = 500,
  parameter int FAST_TICKS     = 100,
  parameter int CODE_ON_TICKS  = 200,
  parameter int CODE_OFF_TICKS = 200,
  parameter int CODE_GAP_TICKS = 1000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              tick,
  input  logic [2:0]        mode,
  input  logic [CODE_W-1:0] code,
  output logic              led,
  output logic              wrap
);

  localparam int PW = phase_width(SLOW_TICKS, FAST_TICKS, CODE_ON_TICKS,
                                  CODE_OFF_TICKS, CODE_GAP_TICKS);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_TICKS - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_TICKS - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(CODE_ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(CODE_OFF_TICKS - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(CODE_GAP_TICKS - 1);

  code_state_e       state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] fc_q, fc_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              led_q, led_d;
  logic              wrap_q, wrap_d;
  logic              half_last;

  assign half_last = (mode_q == MODE_SLOW) ? (phase_q == SLOW_LAST) : (phase_q == FAST_LAST);

  // State register; reset aborts any pattern in progress on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      code_q  <= '0;
      fc_q    <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
      fc_q    <= fc_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: a mode/code change restarts the pattern and wins over a coincident tick.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    code_d  = code_q;
    fc_d    = fc_q;
    phase_d = phase_q;
    led_d   = led_q;
    wrap_d  = 1'b0;
    if (mode != mode_q || code != code_q) begin
      mode_d  = mode;
      code_d  = code;
      fc_d    = '0;
      phase_d = '0;
      state_d = ST_IDLE;
      case (mode)
        MODE_ON, MODE_SLOW, MODE_FAST: led_d = 1'b1;
        MODE_CODE: begin
          led_d = (code != '0);
          if (code != '0) state_d = ST_ON;
        end
        default: led_d = 1'b0;  // off and reserved modes
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_OFF, MODE_ON: ;  // static levels, no timing
        MODE_SLOW, MODE_FAST: begin
          if (half_last) begin
            phase_d = '0;
            led_d   = ~led_q;
            wrap_d  = ~led_q;  // a new period begins on the rising toggle
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        MODE_CODE: begin
          case (state_q)
            ST_ON: begin
              if (phase_q == ON_LAST) begin
                phase_d = '0;
                state_d = ST_OFF;
                led_d   = 1'b0;
                fc_d    = fc_q + CODE_W'(1);
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end
            ST_OFF: begin
              if (phase_q == OFF_LAST) begin
                phase_d = '0;
                if (fc_q == code_q) begin
                  state_d = ST_GAP;
                end else begin
                  state_d = ST_ON;
                  led_d   = 1'b1;
                end
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end
            ST_GAP: begin
              if (phase_q == GAP_LAST) begin
                phase_d = '0;
                state_d = ST_ON;
                led_d   = 1'b1;
                fc_d    = '0;
                wrap_d  = 1'b1;
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end
            default: ;  // IDLE: a zero flash count stays dark
          endcase
        end
        default: ;  // reserved modes behave as off
      endcase
    end
  end

  assign led  = led_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel status-LED driver: shared ms-scale prescaler feeding per-channel sequencers.
// Latency: LED/WRAP are registered and follow MODE/CODE changes one cycle later.
// No backpressure: inputs are levels sampled every cycle, outputs free-run.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int TICK_HZ        = 1000,
  parameter int CHANNELS       = 4,
  parameter int CODE_W         = 4,
  parameter int SLOW_TICKS     = 500,
  parameter int FAST_TICKS     = 100,
  parameter int CODE_ON_TICKS  = 200,
  parameter int CODE_OFF_TICKS = 200,
  parameter int CODE_GAP_TICKS = 1000
) (
  input  logic              CLK,
  input  logic              RESET,
  led_pattern_gen_if.slave  bus
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // Free-running prescaler; only reset restarts it, never a mode change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_pattern_chan #(
      .CODE_W         (CODE_W),
      .SLOW_TICKS     (SLOW_TICKS),
      .FAST_TICKS     (FAST_TICKS),
      .CODE_ON_TICKS  (CODE_ON_TICKS),
      .CODE_OFF_TICKS (CODE_OFF_TICKS),
      .CODE_GAP_TICKS (CODE_GAP_TICKS)
    ) u_chan (
      .CLK   (CLK),
      .RESET (RESET),
      .tick  (tick),
      .mode  (bus.MODE[3*i +: 3]),
      .code  (bus.CODE[CODE_W*i +: CODE_W]),
      .led   (bus.LED[i]),
      .wrap  (bus.WRAP[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a tick-indexed pattern reference model.
// Expected LED/WRAP come from pattern tables indexed by ticks elapsed since restart.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_led_pattern_gen;

  localparam int CH     = 2;
  localparam int CW     = 4;
  localparam int TDIV   = 10;
  localparam int H_SLOW = 5;
  localparam int H_FAST = 2;
  localparam int C_ON   = 2;
  localparam int C_OFF  = 1;
  localparam int C_GAP  = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;

  led_pattern_gen_if #(.CHANNELS(CH), .CODE_W(CW)) bus ();

  led_pattern_gen #(
    .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(CH), .CODE_W(CW),
    .SLOW_TICKS(H_SLOW), .FAST_TICKS(H_FAST), .CODE_ON_TICKS(C_ON),
    .CODE_OFF_TICKS(C_OFF), .CODE_GAP_TICKS(C_GAP)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int cyc = 0;                       // rising edges since reset release
  int m_mode [CH] = '{default: 0};
  int m_code [CH] = '{default: 0};
  int n_t    [CH] = '{default: 0};   // ticks since last restart
  logic [CH-1:0] exp_led  = '0;
  logic [CH-1:0] exp_wrap = '0;

  // Pattern period in ticks; 0 means a static level.
  function automatic int pat_period(input int md, input int cd);
    case (md)
      2: return 2 * H_SLOW;
      3: return 2 * H_FAST;
      4: return (cd > 0) ? cd * (C_ON + C_OFF) + C_GAP : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic pat_level(input int md, input int cd, input int n);
    int p;
    int t;
    case (md)
      1: return 1'b1;
      2: return ((n / H_SLOW) % 2) == 0;
      3: return ((n / H_FAST) % 2) == 0;
      4: begin
        if (cd == 0) return 1'b0;
        p = pat_period(md, cd);
        t = n % p;
        return (t < cd * (C_ON + C_OFF)) && ((t % (C_ON + C_OFF)) < C_ON);
      end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      cyc = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_code[c] = 0; n_t[c] = 0;
      end
      exp_led  = '0;
      exp_wrap = '0;
    end else begin
      automatic logic tick_now = ((cyc % TDIV) == TDIV - 1);
      cyc++;
      for (int c = 0; c < CH; c++) begin
        automatic int md = int'(bus.MODE[3*c +: 3]);
        automatic int cd = int'(bus.CODE[CW*c +: CW]);
        exp_wrap[c] = 1'b0;
        if (md != m_mode[c] || cd != m_code[c]) begin
          m_mode[c]  = md;
          m_code[c]  = cd;
          n_t[c]     = 0;
          exp_led[c] = pat_level(md, cd, 0);
        end else if (tick_now && pat_period(md, cd) > 0) begin
          n_t[c]++;
          exp_led[c]  = pat_level(md, cd, n_t[c]);
          exp_wrap[c] = (n_t[c] % pat_period(md, cd)) == 0;
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1;
    bus.MODE = '0;
    bus.CODE = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== 2'b00 || bus.WRAP !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_hold LED=%b WRAP=%b expected LED=00 WRAP=00", bus.LED, bus.WRAP);
      end
    end
    RESET = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== 2'b00 || bus.WRAP !== 2'b00 || bus.LED !== exp_led) begin
        tests_failed++;
        $display("FAIL reset_off cyc=%0d LED=%b WRAP=%b expected LED=00 WRAP=00", cyc, bus.LED, bus.WRAP);
      end
    end
  endtask

  task automatic test_blink();
    int w[$];
    int hi = 0;
    bus.MODE[2:0] = 3'd2;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        tests_run++;
        if (bus.LED[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL blink_start LED0=%b expected 1", bus.LED[0]);
        end
      end
      if (bus.WRAP[0] === 1'b1) w.push_back(k);
      if (w.size() == 1 && bus.LED[0] === 1'b1) hi++;
      tests_run++;
      if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL blink_model cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
    tests_run++;
    if (w.size() < 2) begin
      tests_failed++;
      $display("FAIL blink_wrap_count got %0d pulses expected at least 2", w.size());
    end else begin
      tests_run++;
      if (w[1] - w[0] !== 100) begin
        tests_failed++;
        $display("FAIL blink_period got %0d cycles expected 100", w[1] - w[0]);
      end
      if (hi !== 50) begin
        tests_failed++;
        $display("FAIL blink_duty got %0d lit cycles expected 50", hi);
      end
    end
  endtask

  task automatic test_code();
    int w[$];
    int hi = 0;
    bus.MODE[5:3] = 3'd4;
    bus.CODE[7:4] = 4'd3;
    for (int k = 0; k < 320; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        tests_run++;
        if (bus.LED[1] !== 1'b1) begin
          tests_failed++;
          $display("FAIL code_start LED1=%b expected 1", bus.LED[1]);
        end
      end
      if (bus.WRAP[1] === 1'b1) w.push_back(k);
      if (w.size() == 1 && bus.LED[1] === 1'b1) hi++;
      tests_run++;
      if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL code_model cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
    tests_run++;
    if (w.size() < 2) begin
      tests_failed++;
      $display("FAIL code_wrap_count got %0d pulses expected at least 2", w.size());
    end else begin
      tests_run++;
      if (w[1] - w[0] !== 130) begin
        tests_failed++;
        $display("FAIL code_period got %0d cycles expected 130", w[1] - w[0]);
      end
      if (hi !== 60) begin
        tests_failed++;
        $display("FAIL code_lit got %0d lit cycles expected 60", hi);
      end
    end
  endtask

  task automatic test_mode_change_on_tick();
    int g = 0;
    bus.MODE[2:0] = 3'd3;
    for (int k = 0; k < 45; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL fast_model cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
    while ((cyc % TDIV) != TDIV - 1 && g < 20) begin
      @(negedge CLK);
      g++;
    end
    tests_run++;
    if (g >= 20) begin
      tests_failed++;
      $display("FAIL tick_align_timeout waited %0d cycles expected under 20", g);
    end
    bus.MODE[2:0] = 3'd1;  // changes in the cycle whose edge carries a tick
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED[0] !== 1'b1 || bus.WRAP[0] !== 1'b0 || bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL tick_change cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    while (bus.LED[1] !== 1'b1 && g < 200) begin
      @(negedge CLK);
      g++;
    end
    tests_run++;
    if (g >= 200) begin
      tests_failed++;
      $display("FAIL mid_flash_timeout waited %0d cycles for LED1", g);
    end
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== 2'b00 || bus.WRAP !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_mid LED=%b WRAP=%b expected LED=00 WRAP=00", bus.LED, bus.WRAP);
      end
    end
    RESET = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.LED !== 2'b11 || bus.WRAP !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_restart LED=%b WRAP=%b expected LED=11 WRAP=00", bus.LED, bus.WRAP);
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL restart_model cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      automatic int len = $urandom_range(60, 400);
      for (int c = 0; c < CH; c++) begin
        bus.MODE[3*c +: 3]   = 3'($urandom_range(0, 7));
        bus.CODE[CW*c +: CW] = 4'($urandom_range(0, 15));
      end
      for (int k = 0; k < len; k++) begin
        @(negedge CLK);
        tests_run++;
        if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
          tests_failed++;
          $display("FAIL random_model r=%0d cyc=%0d MODE=%h CODE=%h LED=%b WRAP=%b expected LED=%b WRAP=%b",
                   r, cyc, bus.MODE, bus.CODE, bus.LED, bus.WRAP, exp_led, exp_wrap);
        end
      end
    end
  endtask

  task automatic test_max_code();
    int nw = 0;
    bus.MODE = {3'd0, 3'd2};
    @(negedge CLK);
    bus.MODE[5:3] = 3'd4;
    bus.CODE[7:4] = 4'd15;
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK);
      if (bus.WRAP[1] === 1'b1) nw++;
      tests_run++;
      if (bus.LED !== exp_led || bus.WRAP !== exp_wrap) begin
        tests_failed++;
        $display("FAIL maxcode_model cyc=%0d LED=%b WRAP=%b expected LED=%b WRAP=%b", cyc, bus.LED, bus.WRAP, exp_led, exp_wrap);
      end
    end
    tests_run++;
    if (nw !== 2) begin
      tests_failed++;
      $display("FAIL maxcode_wraps got %0d pulses expected 2", nw);
    end
  endtask

  task automatic test_idle_modes();
    bus.MODE = {3'd6, 3'd4};
    bus.CODE = {4'd5, 4'd0};
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.LED !== 2'b00 || bus.WRAP !== 2'b00 || bus.LED !== exp_led) begin
        tests_failed++;
        $display("FAIL idle_dark cyc=%0d LED=%b WRAP=%b expected LED=00 WRAP=00", cyc, bus.LED, bus.WRAP);
      end
    end
  endtask

  initial begin
    bus.MODE = '0;
    bus.CODE = '0;
    test_reset();
    test_blink();
    test_code();
    test_mode_change_on_tick();
    test_reset_mid();
    test_random();
    test_max_code();
    test_idle_modes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
